// File: rtl/hba_master_arbiter_if.sv
// Bus bundle between the HBA masters, the round-robin arbiter and the shared slave bus.
// The arbiter takes the "master" view; the masters/slaves side takes the "slave" view.
interface hba_master_arbiter_if #(
    parameter int NUM_MASTERS = 4,
    parameter int DBUS_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 12
);
    logic [NUM_MASTERS-1:0]            hba_mrequest_m;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0] hba_abus_m;
    logic [NUM_MASTERS-1:0]            hba_rnw_m;
    logic [NUM_MASTERS-1:0]            hba_select_m;
    logic [NUM_MASTERS*DBUS_WIDTH-1:0] hba_dbus_m;
    logic [NUM_MASTERS-1:0]            hba_mgrant_m;
    logic [ADDR_WIDTH-1:0]             hba_abus;
    logic                              hba_rnw;
    logic                              hba_select;
    logic [DBUS_WIDTH-1:0]             hba_dbus_master;

    modport master (
        input  hba_mrequest_m, hba_abus_m, hba_rnw_m, hba_select_m, hba_dbus_m,
        output hba_mgrant_m, hba_abus, hba_rnw, hba_select, hba_dbus_master
    );

    modport slave (
        output hba_mrequest_m, hba_abus_m, hba_rnw_m, hba_select_m, hba_dbus_m,
        input  hba_mgrant_m, hba_abus, hba_rnw, hba_select, hba_dbus_master
    );
endinterface

// File: rtl/hba_master_arbiter.sv
// Round-robin arbiter sharing the HBA master port, with a hold-timeout watchdog.
//   state | meaning
//   IDLE  | no grant; pick next eligible requester after last_owner
//   GRANT | owner holds the bus until it drops its request or the watchdog fires
module hba_master_arbiter #(
    parameter int NUM_MASTERS       = 4,
    parameter int DBUS_WIDTH        = 8,
    parameter int PERIPH_ADDR_WIDTH = 4,
    parameter int REG_ADDR_WIDTH    = 8,
    parameter int ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES    = 1024
) (
    input  logic                       hba_clk,
    input  logic                       hba_reset,
    hba_master_arbiter_if.master       bus,
    output logic                       timeout_err,
    output logic [2:0]                 timeout_id
);
    localparam int OW = $clog2(NUM_MASTERS);
    localparam int HW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [OW-1:0] OWNER_MAX = OW'(NUM_MASTERS - 1);
    localparam logic [NUM_MASTERS-1:0] ONE_HOT0 = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                 state, state_nxt;
    logic [OW-1:0]          owner, owner_nxt;
    logic [OW-1:0]          last_owner, last_nxt;
    logic [NUM_MASTERS-1:0] grant, grant_nxt;
    logic [NUM_MASTERS-1:0] mask, mask_nxt, mask_set;
    logic [HW-1:0]          hold_cnt, hold_nxt;
    logic                   err_nxt;
    logic [2:0]             id_nxt;
    logic [NUM_MASTERS-1:0] eligible;
    logic [OW-1:0]          idx, pick;
    logic                   found;

    always_ff @(posedge hba_clk or posedge hba_reset) begin
        if (hba_reset) begin
            state       <= IDLE;
            owner       <= '0;
            last_owner  <= OWNER_MAX;
            grant       <= '0;
            mask        <= '0;
            hold_cnt    <= '0;
            timeout_err <= 1'b0;
            timeout_id  <= '0;
        end else begin
            state       <= state_nxt;
            owner       <= owner_nxt;
            last_owner  <= last_nxt;
            grant       <= grant_nxt;
            mask        <= mask_nxt;
            hold_cnt    <= hold_nxt;
            timeout_err <= err_nxt;
            timeout_id  <= id_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        last_nxt  = last_owner;
        grant_nxt = grant;
        hold_nxt  = hold_cnt;
        err_nxt   = timeout_err;
        id_nxt    = timeout_id;
        mask_set  = '0;
        idx       = '0;
        pick      = '0;
        found     = 1'b0;
        eligible  = bus.hba_mrequest_m & ~mask;

        // Rotating priority: search upward from the slot after the last grantee.
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            idx = OW'((int'(last_owner) + k) % NUM_MASTERS);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end

        case (state)
            IDLE: begin
                if (found) begin
                    owner_nxt = pick;
                    last_nxt  = pick;
                    grant_nxt = ONE_HOT0 << pick;
                    hold_nxt  = '0;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (!bus.hba_mrequest_m[owner]) begin
                    grant_nxt = '0;
                    state_nxt = IDLE;
                end else if (TIMEOUT_CYCLES != 0 && hold_cnt == HOLD_LAST) begin
                    grant_nxt       = '0;
                    state_nxt       = IDLE;
                    mask_set[owner] = 1'b1;
                    err_nxt         = 1'b1;
                    id_nxt          = 3'(owner);
                end else if (hold_cnt != '1) begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A revoked master stays masked until it lets go of its request.
        mask_nxt = (mask & bus.hba_mrequest_m) | mask_set;
    end

    always_comb begin
        bus.hba_mgrant_m    = grant;
        bus.hba_abus        = '0;
        bus.hba_rnw         = 1'b0;
        bus.hba_select      = 1'b0;
        bus.hba_dbus_master = '0;
        if (state == GRANT) begin
            bus.hba_abus        = bus.hba_abus_m[owner*ADDR_WIDTH +: ADDR_WIDTH];
            bus.hba_rnw         = bus.hba_rnw_m[owner];
            bus.hba_select      = bus.hba_select_m[owner];
            bus.hba_dbus_master = bus.hba_dbus_m[owner*DBUS_WIDTH +: DBUS_WIDTH];
        end
    end
endmodule

// File: doc/hba_master_arbiter.md
# hba_master_arbiter

Round-robin arbiter that shares the single HBA bus master port between up to NUM_MASTERS bus masters, e.g. the tablebot sequencer, a UART bridge and future controllers. It sits between the masters and the HBA slave peripherals. It collects each master's hba_mrequest, issues one registered hba_mgrant at a time, and multiplexes the granted master's address, control and write data onto the shared bus. A hold-timeout watchdog revokes a grant from a master that never releases the bus.

## Interface
- NUM_MASTERS, 4: number of requesters, 2..8.
- DBUS_WIDTH, 8: data bus width.
- PERIPH_ADDR_WIDTH, 4: peripheral slot address bits.
- REG_ADDR_WIDTH, 8: register address bits.
- ADDR_WIDTH, PERIPH_ADDR_WIDTH+REG_ADDR_WIDTH: bus address width.
- TIMEOUT_CYCLES, 1024: maximum grant hold time in cycles. 0 disables the watchdog.

Ports, with clock and reset first:
- hba_clk, in, 1: the single clock for the block.
- hba_reset, in, 1: reset, asynchronous and active-high.
- hba_mrequest_m, in, NUM_MASTERS: bit i is master i's bus request.
- hba_abus_m, in, NUM_MASTERS*ADDR_WIDTH: master i's address is slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- hba_rnw_m, in, NUM_MASTERS: per-master read-not-write.
- hba_select_m, in, NUM_MASTERS: per-master select.
- hba_dbus_m, in, NUM_MASTERS*DBUS_WIDTH: per-master write data, sliced the same way as the address.
- hba_mgrant_m, out, NUM_MASTERS: one-hot or zero grant, registered.
- hba_abus, out, ADDR_WIDTH: muxed address to the slaves.
- hba_rnw, out, 1: muxed read-not-write.
- hba_select, out, 1: muxed select.
- hba_dbus_master, out, DBUS_WIDTH: muxed write data.
- timeout_err, out, 1: sticky flag, set when any grant is revoked by the watchdog.
- timeout_id, out, 3: index of the most recently revoked master.

## Operation
- **States:** IDLE and GRANT. The owner index is held in a register, and last_owner holds the most recent grantee.
- **IDLE:**
  - Eligible masters are those with mrequest high and their mask bit clear.
  - If any master is eligible, pick the first eligible index searching upward from last_owner+1, wrapping modulo NUM_MASTERS.
  - Set the owner and last_owner to that index, assert its grant bit, clear the hold counter, and go to GRANT.
  - Simultaneous requests are resolved purely by this rotating priority.
- **GRANT:**
  - If the owner's mrequest is low, drop the grant and go to IDLE.
  - Otherwise, if TIMEOUT_CYCLES≠0 and hold_cnt==TIMEOUT_CYCLES-1:
    - drop the grant and go to IDLE;
    - set the owner's mask bit;
    - set timeout_err to 1 and timeout_id to the owner.
  - Otherwise increment hold_cnt.
  - Requests from other masters are ignored while in GRANT; there is no preemption.
- **Mask:**
  - Mask bit i clears in any cycle where mrequest_m[i] is low.
  - A revoked master must drop its request before it can be granted again.
- **Mux:**
  - The bus outputs are combinational from the owner's slices while the grant is active.
  - They are all zero when no grant is active, so the address is zero when the bus is inactive.
- **xferack and hba_dbus:** both are broadcast to all masters outside this block. The arbiter does not touch them.
- **Widths:**
  - hold_cnt is clog2(TIMEOUT_CYCLES+1) bits and saturates.
  - The owner index is clog2(NUM_MASTERS) bits.
  - timeout_id is zero-extended to 3 bits.

## Timing
- **Reset (async):**
  - state=IDLE, hba_mgrant_m=0, owner=0.
  - last_owner=NUM_MASTERS-1, so master 0 has first priority.
  - mask=0, hold_cnt=0, timeout_err=0, timeout_id=0.
  - All bus outputs are 0.
- **Grant latency:** a request sampled high at edge N in IDLE gives the grant high after edge N, i.e. 1 cycle.
- **Release:**
  - The owner's mrequest sampled low at edge N drops the grant after edge N. The bus outputs are zero in the following cycle.
  - The next grant is issued at edge N+1 at the earliest. This guarantees at least 1 dead cycle between owners.
- **Timeout:** the grant is held for exactly TIMEOUT_CYCLES cycles, then drops. timeout_err rises on the same edge.
- **Reset mid-transfer:**
  - The grant and bus outputs go to 0 immediately, without waiting for a clock edge.
  - Masters must tolerate an aborted transfer.
- **Request glitch:** if the owner drops and re-raises its request in consecutive cycles, it loses the grant. It re-enters round-robin behind the other requesters.

## Test plan
- **Reset priority:** masters 0 and 2 request together after reset → grant=0001 one cycle later. Master 0 releases → one dead cycle, then grant=0100.
- **Round robin:** all 4 masters hold their requests, each releasing after 3 cycles of grant → grant order 0,1,2,3,0. Each grant lasts 3 cycles, with a 1-cycle gap between grants.
- **Mux:** master 1 is granted with abus=0x301, rnw=0, select=1, dbus=0xA5 while the other masters drive 0xFFF and 0xFF → the bus shows 0x301, 0, 1, 0xA5. After release all outputs are 0.
- **Timeout:** with TIMEOUT_CYCLES=16, master 3 holds its request forever → the grant drops after 16 cycles, timeout_err=1, timeout_id=3, and master 3 is not regranted. Master 3 drops its request for 1 cycle and re-raises it → it is granted.
- **Async reset mid-grant:** hba_reset pulses between edges while master 2 is granted → grant, hba_select and hba_abus are 0 before the next edge. After reset, master 0 wins first.
- **No preemption:** master 0 is granted and master 1 requests mid-transfer → the grant stays 0001 until master 0 releases.
